// File: rtl/us_fifo_frame_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : us_fifo_frame_arbiter_if
//  Purpose  : Merged output beat stream between the arbiter and the framer.
//  Revision : 1.0 - initial release
// ============================================================================
interface us_fifo_frame_arbiter_if;
    logic [127:0] m_data;
    logic         m_valid;
    logic         m_ready;
    logic [3:0]   m_chan;
    logic         m_sof;
    logic         m_eof;

    modport master (
        output m_data,
        output m_valid,
        output m_chan,
        output m_sof,
        output m_eof,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_chan,
        input  m_sof,
        input  m_eof,
        output m_ready
    );
endinterface
`default_nettype wire

// File: rtl/us_fifo_frame_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : us_fifo_frame_arbiter
//  Purpose  : Round-robin drain of FWFT FIFOs into one 128-bit message stream.
//  Revision : 1.0 - initial release
// ============================================================================
module us_fifo_frame_arbiter #(
    parameter int          US_CHANNEL = 6,
    parameter logic [31:0] SYNC_WORD  = 32'hFDF7EB90,
    parameter int          CNT_W      = 18
) (
    input  wire logic                      sys_clk_i,
    input  wire logic                      sys_rst_i,
    input  wire logic [US_CHANNEL*128-1:0] rd_din_i,
    input  wire logic [US_CHANNEL-1:0]     rd_empty_i,
    output logic      [US_CHANNEL-1:0]     rd_en_o,
    us_fifo_frame_arbiter_if.master        m_if,
    output logic      [15:0]               hdr_err_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_FWD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         sel_q, sel_d;
    logic [3:0]         ptr_q, ptr_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [15:0]        err_q, err_d;
    logic [127:0]       data_q, data_d;
    logic               valid_q, valid_d;
    logic [3:0]         chan_q, chan_d;
    logic               sof_q, sof_d;
    logic               eof_q, eof_d;

    logic [127:0]       w_head;
    logic               w_sel_empty;
    logic               w_space;
    logic               w_pop;
    logic               w_found;
    logic [3:0]         w_ptr_next;
    int                 w_idx;

    assign w_space    = !valid_q || m_if.m_ready;
    assign w_ptr_next = (sel_q == 4'(US_CHANNEL - 1)) ? 4'd0 : sel_q + 4'd1;

    always_comb begin
        w_head      = '0;
        w_sel_empty = 1'b1;
        for (int k = 0; k < US_CHANNEL; k++) begin
            if (sel_q == 4'(k)) begin
                w_head      = rd_din_i[128*k +: 128];
                w_sel_empty = rd_empty_i[k];
            end
        end
    end

    // Pop strobe is held off during reset so no FIFO word is lost to the abandoned message.
    always_comb begin
        rd_en_o = '0;
        for (int k = 0; k < US_CHANNEL; k++) begin
            rd_en_o[k] = w_pop && !sys_rst_i && (sel_q == 4'(k));
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        err_d   = err_q;
        data_d  = data_q;
        chan_d  = chan_q;
        sof_d   = sof_q;
        eof_d   = eof_q;
        valid_d = valid_q && !m_if.m_ready;
        w_pop   = 1'b0;
        w_found = 1'b0;
        w_idx   = 0;

        case (state_q)
            ST_IDLE: begin
                for (int i = 0; i < US_CHANNEL; i++) begin
                    w_idx = int'(ptr_q) + i;
                    if (w_idx >= US_CHANNEL) w_idx = w_idx - US_CHANNEL;
                    for (int k = 0; k < US_CHANNEL; k++) begin
                        if (!w_found && (w_idx == k) && !rd_empty_i[k]) begin
                            w_found = 1'b1;
                            sel_d   = 4'(k);
                        end
                    end
                end
                if (w_found) state_d = ST_HDR;
            end

            ST_HDR: begin
                if (!w_sel_empty && w_space) begin
                    w_pop = 1'b1;
                    if (w_head[47:16] == SYNC_WORD) begin
                        valid_d = 1'b1;
                        data_d  = w_head;
                        chan_d  = sel_q;
                        sof_d   = 1'b1;
                        eof_d   = 1'b0;
                        // (len+1)*4-1 == {len,2'b11}; fits CNT_W without an intermediate overflow.
                        rem_d   = CNT_W'({w_head[15:0], 2'b11});
                        state_d = ST_FWD;
                    end else begin
                        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                        ptr_d   = w_ptr_next;
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_FWD: begin
                if (!w_sel_empty && w_space) begin
                    w_pop   = 1'b1;
                    valid_d = 1'b1;
                    data_d  = w_head;
                    chan_d  = sel_q;
                    sof_d   = 1'b0;
                    eof_d   = (rem_q == CNT_W'(1));
                    rem_d   = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        ptr_d   = w_ptr_next;
                        state_d = ST_IDLE;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            rem_q   <= '0;
            err_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            chan_q  <= '0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            chan_q  <= chan_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
        end
    end

    assign m_if.m_data   = data_q;
    assign m_if.m_valid  = valid_q;
    assign m_if.m_chan   = chan_q;
    assign m_if.m_sof    = sof_q;
    assign m_if.m_eof    = eof_q;
    assign hdr_err_cnt_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_us_fifo_frame_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_us_fifo_frame_arbiter
//  Purpose  : Self-checking bench; message-level round-robin reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_us_fifo_frame_arbiter;
    localparam int          N    = 6;
    localparam logic [31:0] SYNC = 32'hFDF7EB90;

    typedef struct { logic [127:0] d; bit start; } beat_t;
    typedef struct { logic [127:0] d; logic [3:0] ch; bit sof; bit eof; } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [N*128-1:0]   rd_din;
    logic [N-1:0]       rd_empty;
    logic [N-1:0]       rd_en;
    logic [15:0]        err_cnt;

    us_fifo_frame_arbiter_if m_if ();

    us_fifo_frame_arbiter #(.US_CHANNEL(N), .SYNC_WORD(SYNC), .CNT_W(18)) dut (
        .sys_clk_i     (clk),
        .sys_rst_i     (rst),
        .rd_din_i      (rd_din),
        .rd_empty_i    (rd_empty),
        .rd_en_o       (rd_en),
        .m_if          (m_if),
        .hdr_err_cnt_o (err_cnt)
    );

    always #5 clk = ~clk;

    beat_t        fq [N][$];
    exp_t         exp_q [$];
    int           n_cmp = 0;
    int           n_mis = 0;
    int           model_ptr = 0;
    int           model_err = 0;
    int           ready_pct = 100;
    int           stall_pct = 0;
    int           acc_cnt = 0;
    int           pop_cnt [N];
    bit           prev_valid = 0;
    bit           prev_ready = 0;
    logic [133:0] prev_out;

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic make_msg(int ch, int len, bit bad);
        beat_t b;
        if (bad) begin
            b.d = rnd128(); b.d[47:16] = 32'hDEADBEEF; b.start = 1;
            fq[ch].push_back(b);
        end
        b.d = rnd128(); b.d[47:16] = SYNC; b.d[15:0] = 16'(len); b.start = 1;
        fq[ch].push_back(b);
        for (int j = 1; j < (len + 1) * 4; j++) begin
            b.d = rnd128(); b.start = 0;
            if (j == 1) b.d[47:16] = SYNC;
            fq[ch].push_back(b);
        end
    endtask

    // Message-level view: pick next non-empty channel from ptr, drop a bad header or emit a whole message.
    task automatic run_model();
        beat_t q [N][$];
        beat_t h, b;
        int    sel, n;
        exp_t  e;
        for (int k = 0; k < N; k++) q[k] = fq[k];
        while (1) begin
            sel = -1;
            for (int i = 0; i < N; i++)
                if (sel < 0 && q[(model_ptr + i) % N].size() > 0) sel = (model_ptr + i) % N;
            if (sel < 0) break;
            h = q[sel].pop_front();
            if (h.d[47:16] != SYNC) begin
                if (model_err < 16'hFFFF) model_err++;
            end else begin
                n = (int'(h.d[15:0]) + 1) * 4;
                e.d = h.d; e.ch = 4'(sel); e.sof = 1; e.eof = 0;
                exp_q.push_back(e);
                for (int j = 1; j < n; j++) begin
                    b = q[sel].pop_front();
                    e.d = b.d; e.sof = 0; e.eof = (j == n - 1);
                    exp_q.push_back(e);
                end
            end
            model_ptr = (sel + 1) % N;
        end
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            if (fq[k].size() == 0 || (!fq[k][0].start && $urandom_range(99) < stall_pct)) begin
                rd_empty[k] = 1'b1;
                rd_din[128*k +: 128] = rnd128();
            end else begin
                rd_empty[k] = 1'b0;
                rd_din[128*k +: 128] = fq[k][0].d;
            end
        end
        m_if.m_ready = ($urandom_range(99) < ready_pct);
    endtask

    function automatic bit fifos_pending();
        for (int k = 0; k < N; k++) if (fq[k].size() != 0) return 1;
        return 0;
    endfunction

    task automatic tick();
        logic [N-1:0] pops;
        bit           acc;
        exp_t         e;
        beat_t        tmp;
        @(negedge clk);
        pops = rd_en;
        acc  = m_if.m_valid && m_if.m_ready;
        if (!rst) begin
            chk("rd_en_onehot0", 128'($onehot0(rd_en)), 128'd1);
            chk("pop_of_empty_flag", 128'(rd_en & rd_empty), 128'd0);
            if (prev_valid && !prev_ready) begin
                chk("hold_valid", 128'(m_if.m_valid), 128'd1);
                chk("hold_beat", 128'({m_if.m_data, m_if.m_chan, m_if.m_sof, m_if.m_eof}), 128'(prev_out));
            end
            if (m_if.m_valid && !m_if.m_ready) chk("no_pop_when_full", 128'(rd_en), 128'd0);
            if (m_if.m_valid) chk("sof_eof_exclusive", 128'(m_if.m_sof && m_if.m_eof), 128'd0);
            if (acc) begin
                acc_cnt++;
                if (exp_q.size() == 0) chk("unexpected_beat", 128'd1, 128'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("beat_data", m_if.m_data, e.d);
                    chk("beat_chan", 128'(m_if.m_chan), 128'(e.ch));
                    chk("beat_sof", 128'(m_if.m_sof), 128'(e.sof));
                    chk("beat_eof", 128'(m_if.m_eof), 128'(e.eof));
                end
            end
        end
        prev_valid = m_if.m_valid;
        prev_ready = m_if.m_ready;
        prev_out   = {m_if.m_data, m_if.m_chan, m_if.m_sof, m_if.m_eof};
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (pops[k]) begin
                if (fq[k].size() == 0) chk("pop_beyond_data", 128'd1, 128'd0);
                else begin
                    tmp = fq[k].pop_front();
                    pop_cnt[k]++;
                end
            end
        end
        drive();
    endtask

    task automatic drain(int budget);
        int c = 0;
        while ((exp_q.size() != 0 || fifos_pending() || m_if.m_valid) && c < budget) begin
            tick();
            c++;
        end
        if (c >= budget) chk("drain_timeout", 128'd1, 128'd0);
        repeat (2) tick();
        chk("idle_no_valid", 128'(m_if.m_valid), 128'd0);
        chk("hdr_err_cnt", 128'(err_cnt), 128'(model_err));
    endtask

    task automatic reset_and_check();
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("rst_valid", 128'(m_if.m_valid), 128'd0);
        chk("rst_data", m_if.m_data, 128'd0);
        chk("rst_chan", 128'(m_if.m_chan), 128'd0);
        chk("rst_sof_eof", 128'({m_if.m_sof, m_if.m_eof}), 128'd0);
        chk("rst_err_cnt", 128'(err_cnt), 128'd0);
        rst = 1'b0;
        for (int k = 0; k < N; k++) begin fq[k].delete(); pop_cnt[k] = 0; end
        model_ptr  = 0;
        model_err  = 0;
        prev_valid = 0;
        drive();
        #1;
        chk("rst_rd_en", 128'(rd_en), 128'd0);
    endtask

    task automatic load_and_run(int budget);
        run_model();
        drive();
        drain(budget);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rd_empty = '1;
        rd_din = '0;
        m_if.m_ready = 1'b0;
        for (int k = 0; k < N; k++) pop_cnt[k] = 0;
        repeat (2) @(posedge clk);
        reset_and_check();

        // Single minimal message on ch0
        ready_pct = 100; stall_pct = 0;
        make_msg(0, 0, 0);
        load_and_run(100);
        chk("ch0_pop_count", 128'(pop_cnt[0]), 128'd4);

        // Two channels contending at once
        make_msg(0, 0, 0);
        make_msg(1, 0, 0);
        load_and_run(100);

        // Bad header dropped, then a len-1 message on ch2
        make_msg(2, 1, 1);
        load_and_run(100);
        chk("err_after_bad_hdr", 128'(err_cnt), 128'd1);

        // Backpressure and source stalls on a len-1 message
        ready_pct = 30; stall_pct = 30;
        make_msg(3, 1, 0);
        load_and_run(400);

        // Wrap from ch5 to ch0 with ptr parked at 5
        ready_pct = 100; stall_pct = 0;
        make_msg(4, 0, 0);
        load_and_run(100);
        make_msg(5, 0, 0);
        make_msg(0, 0, 0);
        load_and_run(100);

        // Randomized traffic
        for (int r = 0; r < 6; r++) begin
            ready_pct = 40 + $urandom_range(60);
            stall_pct = $urandom_range(30);
            for (int m = 0; m < 1 + $urandom_range(5); m++)
                make_msg($urandom_range(N - 1), $urandom_range(3), $urandom_range(4) == 0);
            load_and_run(3000);
        end

        // Reset in the middle of a message, then a fresh message on ch3
        ready_pct = 100; stall_pct = 0;
        acc_cnt = 0;
        make_msg(0, 0, 0);
        run_model();
        drive();
        for (int c = 0; c < 50 && acc_cnt < 2; c++) tick();
        chk("beats_before_reset", 128'(acc_cnt), 128'd2);
        reset_and_check();
        make_msg(3, 0, 0);
        load_and_run(100);
        chk("ch3_pop_count", 128'(pop_cnt[3]), 128'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
`default_nettype wire
